// File: rtl/top_pkg.sv
// Shared constants, opcode/funct3 codes and ALU helpers for the RV32I core and its memory.
package top_pkg;

  localparam int unsigned RAM_WORD_CNT = 1024;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [31:0] PASS_WORD = 32'h0000_0001;
  localparam logic [31:0] FAIL_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // SUB exists only for register-register ops; SRA/SRAI both key off instr[30].
  function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt, logic is_reg);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/top_cpu.sv
// Single-cycle RV32I datapath: decode, ALU, register file and program counter.
module top_cpu import top_pkg::*; #(
  parameter int unsigned WORD_CNT = RAM_WORD_CNT,
  localparam int unsigned AW = $clog2(WORD_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   i_rdata,
  input  logic [31:0]   d_rdata,
  output logic [AW-1:0] i_idx_c,
  output logic [AW-1:0] d_idx_c,
  output logic [31:0]   d_wdata_c,
  output logic [3:0]    d_be_c,
  output logic          d_we_c
);

  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4, d_addr, jalr_sum;
  logic [31:0] next_pc, rd_data, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rd_we, taken;
  logic        unused_addr_bits;

  assign opcode   = i_rdata[6:0];
  assign rd       = i_rdata[11:7];
  assign f3       = i_rdata[14:12];
  assign rs1      = i_rdata[19:15];
  assign rs2      = i_rdata[24:20];
  assign imm_i    = {{20{i_rdata[31]}}, i_rdata[31:20]};
  assign imm_s    = {{20{i_rdata[31]}}, i_rdata[31:25], i_rdata[11:7]};
  assign imm_b    = {{19{i_rdata[31]}}, i_rdata[31], i_rdata[7], i_rdata[30:25], i_rdata[11:8], 1'b0};
  assign imm_u    = {i_rdata[31:12], 12'b0};
  assign imm_j    = {{11{i_rdata[31]}}, i_rdata[31], i_rdata[19:12], i_rdata[20], i_rdata[30:21], 1'b0};
  assign rs1_val  = regs[rs1];
  assign rs2_val  = regs[rs2];
  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1_val + imm_i;
  assign d_addr   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  // Addresses wrap through the memory index bits; the upper bits are intentionally dropped.
  assign i_idx_c          = pc[AW+1:2];
  assign d_idx_c          = d_addr[AW+1:2];
  assign unused_addr_bits = ^{d_addr[31:AW+2], pc[31:AW+2]};

  // Branch condition and load lane extraction.
  always_comb begin
    taken   = 1'b0;
    ld_byte = d_rdata[7:0];
    ld_half = d_addr[1] ? d_rdata[31:16] : d_rdata[15:0];
    ld_val  = d_rdata;
    case (f3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val < rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
    case (d_addr[1:0])
      2'd0:    ld_byte = d_rdata[7:0];
      2'd1:    ld_byte = d_rdata[15:8];
      2'd2:    ld_byte = d_rdata[23:16];
      default: ld_byte = d_rdata[31:24];
    endcase
    case (f3)
      F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_val = {24'b0, ld_byte};
      F3_HU:   ld_val = {16'b0, ld_half};
      default: ld_val = d_rdata;
    endcase
  end

  // Main decode: next pc, register writeback and store lane generation.
  always_comb begin
    next_pc   = pc_plus4;
    rd_we     = 1'b0;
    rd_data   = '0;
    d_we_c    = 1'b0;
    d_be_c    = 4'b0000;
    d_wdata_c = rs2_val;
    case (opcode)
      OPC_LUI:   begin rd_we = 1'b1; rd_data = imm_u; end
      OPC_AUIPC: begin rd_we = 1'b1; rd_data = pc + imm_u; end
      OPC_JAL:   begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:  begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = jalr_sum & 32'hFFFF_FFFE; end
      OPC_BRANCH: if (taken) next_pc = pc + imm_b;
      OPC_LOAD:  begin rd_we = 1'b1; rd_data = ld_val; end
      OPC_STORE: begin
        d_we_c = rst_n;
        case (f3)
          F3_B: begin d_be_c = 4'b0001 << d_addr[1:0]; d_wdata_c = {4{rs2_val[7:0]}}; end
          F3_H: begin d_be_c = d_addr[1] ? 4'b1100 : 4'b0011; d_wdata_c = {2{rs2_val[15:0]}}; end
          F3_W: d_be_c = 4'b1111;
          default: d_be_c = 4'b0000;
        endcase
      end
      OPC_OP_IMM: begin
        rd_we   = 1'b1;
        rd_data = alu_exec(alu_decode(f3, i_rdata[30], 1'b0), rs1_val, imm_i);
      end
      OPC_OP: begin
        rd_we   = 1'b1;
        rd_data = alu_exec(alu_decode(f3, i_rdata[30], 1'b1), rs1_val, rs2_val);
      end
      default: ;
    endcase
  end

  // x0 is never written, so clearing it at reset keeps it permanently zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_data;
    end
  end

endmodule

// File: rtl/top_ram.sv
// Unified word-organised memory: combinational instruction/data reads, byte-enabled synchronous write.
module top_ram #(
  parameter int unsigned WORD_CNT = 1024,
  localparam int unsigned AW = $clog2(WORD_CNT)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_idx,
  input  logic [AW-1:0] d_idx,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  input  logic          d_we,
  output logic [31:0]   i_rdata_c,
  output logic [31:0]   d_rdata_c
);

  logic [31:0] ram [WORD_CNT];

  assign i_rdata_c = ram[i_idx];
  assign d_rdata_c = ram[d_idx];

  // Contents are preloaded externally and deliberately have no reset.
  always_ff @(posedge clk) begin
    if (d_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) ram[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/top.sv
// Processor integration: RV32I core wired to a unified instruction/data memory.
module top #(
  parameter int unsigned RAM_WORD_CNT = top_pkg::RAM_WORD_CNT
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned AW = $clog2(RAM_WORD_CNT);

  logic [AW-1:0] i_idx, d_idx;
  logic [31:0]   i_read, d_read, d_wdata;
  logic [3:0]    d_be;
  logic          d_we;

  top_cpu #(.WORD_CNT(RAM_WORD_CNT)) cpu (
    .clk       (clk),
    .rst_n     (reset),
    .i_rdata   (i_read),
    .d_rdata   (d_read),
    .i_idx_c   (i_idx),
    .d_idx_c   (d_idx),
    .d_wdata_c (d_wdata),
    .d_be_c    (d_be),
    .d_we_c    (d_we)
  );

  top_ram #(.WORD_CNT(RAM_WORD_CNT)) ram (
    .clk       (clk),
    .i_idx     (i_idx),
    .d_idx     (d_idx),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_we      (d_we),
    .i_rdata_c (i_read),
    .d_rdata_c (d_read)
  );

endmodule

// File: tb/tb_top.sv
// Directed programs run on top; expected architectural state is queued at load and checked at the pass word.
module tb_top;

  logic clk = 1'b0;
  logic reset = 1'b0;

  top dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic exp_reg(input string tag, input int r, input logic [31:0] v);
    sb.push_back('{tag, 0, r, v});
  endtask

  task automatic exp_mem(input string tag, input int byte_addr, input logic [31:0] v);
    sb.push_back('{tag, 1, byte_addr >> 2, v});
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 0) obs = dut.cpu.regs[e.idx];
      else             obs = dut.ram.ram[e.idx];
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.ram.ram[i] = 32'h0;
  endtask

  task automatic put(input int byte_addr, input logic [31:0] w);
    dut.ram.ram[byte_addr >> 2] = w;
  endtask

  // Release reset, run until the pass/fail word is fetched, then compare queued expectations.
  task automatic run_prog(input string name, input int max_cyc);
    bit done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dut.i_read === 32'h1 || dut.i_read === 32'h0) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_timeout: observed no end word expected pass within %0d cycles", name, max_cyc);
    end else begin
      chk({name, "_end_word"}, dut.i_read, 32'h1);
    end
    drain();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] e_i(input logic [6:0] op, input int rd, input int f3,
                                      input int rs1, input logic [31:0] imm);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_s(input int f3, input int rs1, input int rs2, input logic [31:0] imm);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(input int f3, input int rs1, input int rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_u(input logic [6:0] op, input int rd, input logic [31:0] imm);
    return {imm[31:12], 5'(rd), op};
  endfunction

  function automatic logic [31:0] e_j(input int rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] e_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input logic [31:0] imm);
    return e_i(7'h13, rd, 0, rs1, imm);
  endfunction

  initial begin
    // Reset state and first fetch.
    clear_mem();
    put(0, 32'h1);
    #1;
    chk("rst_pc", dut.cpu.pc, 32'h0);
    chk("rst_i_read", dut.i_read, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #4;
    chk("first_edge_i_read", dut.i_read, 32'h1);
    chk("first_edge_pc", dut.cpu.pc, 32'h0);
    @(posedge clk);
    #1;
    chk("nop_marker_pc", dut.cpu.pc, 32'h4);
    reset = 1'b0;

    // Arithmetic, compare and branches, including x0 write suppression.
    clear_mem();
    put(32'h00, addi(1, 0, 5));
    put(32'h04, addi(2, 1, -3));
    put(32'h08, e_b(0, 2, 0, 32'h1E8));
    put(32'h0C, addi(3, 0, -1));
    put(32'h10, e_r(0, 2, 4, 3, 1));
    put(32'h14, e_r(0, 3, 5, 3, 1));
    put(32'h18, addi(0, 0, 7));
    put(32'h1C, e_b(0, 0, 0, 32'd8));
    put(32'h20, e_j(0, 32'h1D0));
    put(32'h24, e_r(7'h20, 0, 6, 1, 2));
    put(32'h28, 32'h1);
    exp_reg("arith_x0", 0, 32'h0);
    exp_reg("arith_x1", 1, 32'd5);
    exp_reg("arith_x2", 2, 32'd2);
    exp_reg("arith_x3", 3, 32'hFFFF_FFFF);
    exp_reg("arith_slt", 4, 32'd1);
    exp_reg("arith_sltu", 5, 32'd0);
    exp_reg("arith_sub", 6, 32'd3);
    run_prog("arith", 50);

    // Jumps and shifts.
    clear_mem();
    put(32'h00, e_u(7'h37, 5, 32'h8000_0000));
    put(32'h04, addi(6, 0, 4));
    put(32'h08, e_r(7'h20, 5, 7, 5, 6));
    put(32'h0C, e_i(7'h13, 8, 5, 5, 32'h404));
    put(32'h10, e_j(1, 32'd8));
    put(32'h18, e_u(7'h17, 9, 32'h0));
    put(32'h1C, addi(11, 0, 32'h2D));
    put(32'h20, e_i(7'h67, 12, 0, 11, 32'h0));
    put(32'h2C, e_u(7'h17, 13, 32'h0));
    put(32'h30, e_i(7'h13, 10, 5, 5, 32'h4));
    put(32'h34, 32'h1);
    exp_reg("jal_link", 1, 32'h14);
    exp_reg("sra", 7, 32'hF800_0000);
    exp_reg("srai", 8, 32'hF800_0000);
    exp_reg("jal_target_pc", 9, 32'h18);
    exp_reg("jalr_link", 12, 32'h24);
    exp_reg("jalr_bit0_clear", 13, 32'h2C);
    exp_reg("srli", 10, 32'h0800_0000);
    run_prog("jump", 50);

    // Stores, loads, lane selection and load-use forwarding.
    clear_mem();
    put(32'h00, e_u(7'h37, 1, 32'h1234_5000));
    put(32'h04, addi(1, 1, 32'h680));
    put(32'h08, e_s(2, 0, 1, 32'h100));
    put(32'h0C, e_i(7'h03, 3, 0, 0, 32'h100));
    put(32'h10, e_i(7'h03, 5, 4, 0, 32'h100));
    put(32'h14, e_i(7'h03, 4, 5, 0, 32'h102));
    put(32'h18, addi(6, 0, 32'hAA));
    put(32'h1C, e_s(0, 0, 6, 32'h101));
    put(32'h20, e_i(7'h03, 7, 2, 0, 32'h100));
    put(32'h24, e_i(7'h03, 8, 1, 0, 32'h100));
    put(32'h28, e_s(1, 0, 6, 32'h106));
    put(32'h2C, e_i(7'h03, 9, 2, 0, 32'h104));
    put(32'h30, e_r(0, 0, 10, 9, 7));
    put(32'h34, 32'h1);
    exp_reg("ls_x1", 1, 32'h1234_5680);
    exp_reg("lb", 3, 32'hFFFF_FF80);
    exp_reg("lbu", 5, 32'h0000_0080);
    exp_reg("lhu", 4, 32'h0000_1234);
    exp_reg("lw_after_sb", 7, 32'h1234_AA80);
    exp_reg("lh", 8, 32'hFFFF_AA80);
    exp_reg("lw_after_sh", 9, 32'h00AA_0000);
    exp_reg("load_use", 10, 32'h12DE_AA80);
    exp_mem("mem_sb", 32'h100, 32'h1234_AA80);
    exp_mem("mem_sh", 32'h104, 32'h00AA_0000);
    run_prog("ldst", 50);

    // Reset asserted while a store sits at pc 0x40.
    clear_mem();
    for (int i = 0; i < 16; i++) put(4 * i, addi(i + 1, 0, i + 1));
    put(32'h40, e_s(2, 0, 1, 32'h200));
    put(32'h200, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (dut.cpu.pc === 32'h40) hit = 1'b1;
      end
      chk("mid_reach_pc40", dut.cpu.pc, 32'h40);
    end
    chk("mid_x16_before", dut.cpu.regs[16], 32'd16);
    reset = 1'b0;
    #1;
    chk("mid_pc_async", dut.cpu.pc, 32'h0);
    chk("mid_i_read", dut.i_read, addi(1, 0, 1));
    for (int r = 1; r < 32; r++) chk($sformatf("mid_x%0d_clear", r), dut.cpu.regs[r], 32'h0);
    @(posedge clk);
    #1;
    chk("mid_no_store", dut.ram.ram[32'h200 >> 2], 32'hDEAD_BEEF);
    chk("mid_pc_held", dut.cpu.pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
